// File: rtl/aes128_round_ctrl_pkg.sv
// Shared definitions for the AES-128 round controller and its round unit.
// Holds the FSM encoding, cipher constants and GF(2^8) helpers (xtime, S-box).
// The S-box is computed arithmetically (inverse via x^254, then the affine map).
package aes128_round_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int          AES_NR    = 10;
  localparam logic [7:0]  RCON_INIT = 8'h01;
  localparam logic [7:0]  RCON_POLY = 8'h1b;

  // Multiply by x in GF(2^8); also drives the Rcon sequence.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 == x^-1 for nonzero x, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes128_round_unit.sv
// Combinational AES-128 round: SubBytes, ShiftRows, MixColumns, AddRoundKey + one key-expansion step.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the controller samples the outputs every ROUND cycle.
module aes128_round_unit
  import aes128_round_ctrl_pkg::*;
(
  input  logic [127:0] rnd_state,
  input  logic [127:0] rnd_key,
  input  logic [7:0]   rnd_rcon,
  input  logic         rnd_last,
  output logic [127:0] rnd_state_nxt,
  output logic [127:0] rnd_key_nxt
);

  logic [7:0]  sb [16];
  logic [7:0]  sr [16];
  logic [7:0]  mc [16];
  logic [31:0] w0, w1, w2, w3, t, nk0, nk1, nk2, nk3;

  // Byte i lives at [127-8i -: 8]; column c holds bytes 4c..4c+3 (row r = byte 4c+r).
  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[i] = sbox(rnd_state[127-8*i -: 8]);
  end

  // Row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[4*c+r] = sb[4*((c+r)%4)+r];
    end
    assign mc[4*c+0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
    assign mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
  end

  // Next round key: RotWord/SubWord/Rcon on the last word, then the XOR chain.
  assign {w0, w1, w2, w3} = rnd_key;
  assign t   = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rnd_rcon, 24'h0};
  assign nk0 = w0 ^ t;
  assign nk1 = w1 ^ nk0;
  assign nk2 = w2 ^ nk1;
  assign nk3 = w3 ^ nk2;
  assign rnd_key_nxt = {nk0, nk1, nk2, nk3};

  // The final round skips MixColumns.
  for (genvar i = 0; i < 16; i++) begin : g_ark
    assign rnd_state_nxt[127-8*i -: 8] = (rnd_last ? sr[i] : mc[i]) ^ rnd_key_nxt[127-8*i -: 8];
  end

endmodule

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 sequencer: initial AddRoundKey, then NUM_ROUNDS passes through the round unit.
// Latency: handshake cycle T -> out_valid in cycle T+NUM_ROUNDS+1; one block per NUM_ROUNDS+2 cycles.
// Backpressure: in_ready only in IDLE; DONE holds the result until out_ready.
module aes128_round_ctrl
  import aes128_round_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic [127:0] rnd_state,
  output logic [127:0] rnd_key,
  output logic [7:0]   rnd_rcon,
  output logic         rnd_last,
  input  logic [127:0] rnd_state_nxt,
  input  logic [127:0] rnd_key_nxt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  state_e       fsm_q, fsm_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_cnt_q, round_cnt_d;
  logic [7:0]   rcon_q, rcon_d;

  // State register: synchronous reset aborts any operation in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= ST_IDLE;
      blk_q       <= '0;
      key_q       <= '0;
      round_cnt_q <= '0;
      rcon_q      <= RCON_INIT;
    end else begin
      fsm_q       <= fsm_d;
      blk_q       <= blk_d;
      key_q       <= key_d;
      round_cnt_q <= round_cnt_d;
      rcon_q      <= rcon_d;
    end
  end

  // Next-state: load on accept, iterate rounds, hold in DONE until drained.
  always_comb begin
    fsm_d       = fsm_q;
    blk_d       = blk_q;
    key_d       = key_q;
    round_cnt_d = round_cnt_q;
    rcon_d      = rcon_q;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          fsm_d       = ST_ROUND;
          blk_d       = plaintext ^ key;
          key_d       = key;
          round_cnt_d = 4'd1;
          rcon_d      = RCON_INIT;
        end
      end
      ST_ROUND: begin
        blk_d  = rnd_state_nxt;
        key_d  = rnd_key_nxt;
        rcon_d = xtime(rcon_q);
        if (round_cnt_q == LAST_RND) fsm_d = ST_DONE;
        else                         round_cnt_d = round_cnt_q + 4'd1;
      end
      ST_DONE: begin
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state only.
  always_comb begin
    in_ready  = (fsm_q == ST_IDLE);
    out_valid = (fsm_q == ST_DONE);
    busy      = (fsm_q == ST_ROUND) || (fsm_q == ST_DONE);
    rnd_last  = (fsm_q == ST_ROUND) && (round_cnt_q == LAST_RND);
  end

  assign rnd_state  = blk_q;
  assign rnd_key    = key_q;
  assign rnd_rcon   = rcon_q;
  assign ciphertext = blk_q;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
module tb_aes128_round_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] plaintext = '0;
  logic [127:0] key = '0;
  logic [127:0] rnd_state, rnd_key, rnd_state_nxt, rnd_key_nxt;
  logic [7:0]   rnd_rcon;
  logic         rnd_last;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] ciphertext;
  logic         busy;

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [7:0] sbox_t [256];

  aes128_round_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key(key),
    .rnd_state(rnd_state), .rnd_key(rnd_key), .rnd_rcon(rnd_rcon), .rnd_last(rnd_last),
    .rnd_state_nxt(rnd_state_nxt), .rnd_key_nxt(rnd_key_nxt),
    .out_valid(out_valid), .out_ready(out_ready), .ciphertext(ciphertext), .busy(busy)
  );

  aes128_round_unit u_round (
    .rnd_state(rnd_state), .rnd_key(rnd_key), .rnd_rcon(rnd_rcon), .rnd_last(rnd_last),
    .rnd_state_nxt(rnd_state_nxt), .rnd_key_nxt(rnd_key_nxt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box table built with the generator-3 walk, independent of the inverse-by-power method.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  // Reference AES-128 encryption on a 4x4 byte matrix with a full key schedule.
  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [31:0]  tw;
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {sbox_t[tw[23:16]], sbox_t[tw[15:8]], sbox_t[tw[7:0]], sbox_t[tw[31:24]]};
        tw = tw ^ {rcon_tab[i/4-1], 24'h0};
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r][c] = sbox_t[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[0][c]; a1 = t[1][c]; a2 = t[2][c]; a3 = t[3][c];
        if (rd < 10) begin
          t[0][c] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[1][c] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[2][c] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[3][c] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        for (int r = 0; r < 4; r++) s[r][c] = t[r][c] ^ w[4*rd+c][31-8*r -: 8];
      end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  // Offer one block from IDLE, follow it through the rounds, stall in DONE, drain.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] k, input int stall,
                           input bit chk_rounds, output logic [127:0] ct);
    int n;
    plaintext = pt;
    key       = k;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    chk("accept_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      if (chk_rounds && n <= 10) begin
        chk($sformatf("rcon_r%0d", n), rnd_rcon, rcon_tab[n-1]);
        chk($sformatf("last_r%0d", n), rnd_last, (n == 10));
        chk("round_in_ready", in_ready, 1'b0);
        chk("round_busy", busy, 1'b1);
      end
      tick();
      n++;
    end
    chk("latency", n, 11);
    ct = ciphertext;
    for (int s = 0; s < stall; s++) begin
      in_valid  = (s % 2 == 0);
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      chk("stall_out_valid", out_valid, 1'b1);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_busy", busy, 1'b1);
      chk("stall_ct", ciphertext, ct);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("drain_out_valid", out_valid, 1'b1);
    chk("drain_ct", ciphertext, ct);
    tick();
    out_ready = 1'b0;
    chk("idle_in_ready", in_ready, 1'b1);
    chk("idle_out_valid", out_valid, 1'b0);
    chk("idle_busy", busy, 1'b0);
  endtask

  initial begin
    logic [127:0] ct, pt, k;
    logic [127:0] ctb [2];
    int acc_cyc [2];
    int acc, outs, n;
    bit hs;

    build_sbox();
    // Anchor the reference model to the published vector before trusting it on random data.
    chk("model_c1", aes_ref(C1_PT, C1_KEY), C1_CT);

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_last", rnd_last, 1'b0);
    chk("rst_rcon", rnd_rcon, 8'h01);
    chk("rst_state", rnd_state, 128'h0);
    chk("rst_key", rnd_key, 128'h0);

    // FIPS-197 C.1 with round-by-round Rcon/last checks.
    run_block(C1_PT, C1_KEY, 0, 1'b1, ct);
    chk("c1_ct", ct, C1_CT);

    // FIPS-197 App. B with a 5-cycle stall in DONE.
    run_block(B_PT, B_KEY, 5, 1'b1, ct);
    chk("appb_ct", ct, B_CT);

    // Back-to-back with in_valid held and out_ready high.
    plaintext = C1_PT;
    key       = C1_KEY;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    acc  = 0;
    outs = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    for (int i = 0; i < 80 && outs < 2; i++) begin
      hs = in_valid && in_ready;
      if (hs && acc < 2) begin
        acc_cyc[acc] = i;
        acc++;
      end
      if (out_valid && outs < 2) begin
        ctb[outs] = ciphertext;
        outs++;
      end
      tick();
      if (hs) begin
        if (acc == 1) begin
          plaintext = B_PT;
          key       = B_KEY;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_outputs", outs, 2);
    chk("b2b_gap", acc_cyc[1] - acc_cyc[0], 12);
    chk("b2b_ct0", ctb[0], C1_CT);
    chk("b2b_ct1", ctb[1], B_CT);

    // Reset asserted for one cycle in round 5.
    plaintext = C1_PT;
    key       = C1_KEY;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    chk("mid_rcon_r5", rnd_rcon, 8'h10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rcon", rnd_rcon, 8'h01);
    chk("mid_rst_last", rnd_last, 1'b0);
    chk("mid_rst_state", rnd_state, 128'h0);
    run_block(C1_PT, C1_KEY, 0, 1'b0, ct);
    chk("mid_rst_c1_ct", ct, C1_CT);

    // in_valid held through reset: no accept until rst drops.
    plaintext = B_PT;
    key       = B_KEY;
    in_valid  = 1'b1;
    rst       = 1'b1;
    tick();
    chk("rstv_busy0", busy, 1'b0);
    tick();
    chk("rstv_busy1", busy, 1'b0);
    rst = 1'b0;
    chk("rstv_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("rstv_accept", busy, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("rstv_done", out_valid, 1'b1);
    chk("rstv_ct", ciphertext, B_CT);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Random blocks against the reference model, random stall lengths.
    for (int i = 0; i < 8; i++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      run_block(pt, k, int'($urandom_range(0, 3)), 1'b0, ct);
      chk($sformatf("rand%0d_ct", i), ct, aes_ref(pt, k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
